// File: rtl/window_generator_5x5.sv
// 5x5 sliding-window generator: four line buffers feed a 5x5 register window.
// A valid/ready output register emits one window per interior pixel (no edge padding).
module window_generator_5x5 #(
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   pix_in,
    input  logic         pix_valid,
    output logic         pix_ready,
    output logic [199:0] window_out,
    output logic         window_valid,
    input  logic         window_ready,
    output logic         frame_done
);
    localparam int unsigned ColW = $clog2(IMG_WIDTH);
    localparam int unsigned RowW = $clog2(IMG_HEIGHT);
    localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);

    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic [7:0]      line_buf [4][IMG_WIDTH];
    logic [7:0]      win_q [5][5];
    logic [7:0]      win_d [5][5];
    logic [7:0]      new_col [5];
    logic [199:0]    win_flat;
    logic [199:0]    out_q, out_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            in_xfer, out_xfer, win_complete;

    assign pix_ready    = !valid_q || window_ready;
    assign in_xfer      = pix_valid && pix_ready;
    assign out_xfer     = valid_q && window_ready;
    // Only interior pixels complete a window, so stale line-buffer data is never used.
    assign win_complete = in_xfer && (row_q >= RowW'(4)) && (col_q >= ColW'(4));

    assign window_out   = out_q;
    assign window_valid = valid_q;
    assign frame_done   = done_q;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            new_col[r] = line_buf[r][col_q];
        end
        new_col[4] = pix_in;
    end

    always_comb begin
        win_d = win_q;
        if (in_xfer) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][4] = new_col[r];
            end
        end
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                win_flat[40*r + 8*c +: 8] = win_d[r][c];
            end
        end
    end

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        done_d = 1'b0;
        if (in_xfer) begin
            if (col_q == ColLast) begin
                col_d = '0;
                if (row_q == RowLast) begin
                    row_d  = '0;
                    done_d = 1'b1;
                end else begin
                    row_d = row_q + RowW'(1);
                end
            end else begin
                col_d = col_q + ColW'(1);
            end
        end
    end

    // A new window on the same cycle as an output transfer reloads instead of dropping valid.
    always_comb begin
        valid_d = valid_q;
        out_d   = out_q;
        if (win_complete) begin
            valid_d = 1'b1;
            out_d   = win_flat;
        end else if (out_xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '{default: '0};
            out_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_xfer) begin
            for (int r = 0; r < 3; r++) begin
                line_buf[r][col_q] <= line_buf[r+1][col_q];
            end
            line_buf[3][col_q] <= pix_in;
        end
    end

endmodule

// File: tb/tb_window_generator_5x5.sv
// Directed bench for window_generator_5x5 on an 8x8 frame with pixel value 8*row+col.
module tb_window_generator_5x5;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NWIN = 16;

    typedef struct {
        int         row;
        int         col;
        logic [7:0] tl;
        logic [7:0] br;
    } vec_t;

    vec_t vecs [NWIN];

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   pix_in;
    logic         pix_valid;
    logic         pix_ready;
    logic [199:0] window_out;
    logic         window_valid;
    logic         window_ready;
    logic         frame_done;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_done   = 0;
    int           rdy_mode = 1;
    logic [199:0] got_q [$];
    logic [199:0] saved;

    window_generator_5x5 #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_in       (pix_in),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .window_out   (window_out),
        .window_valid (window_valid),
        .window_ready (window_ready),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so a negedge sample sees the upcoming transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (window_valid && window_ready) got_q.push_back(window_out);
            if (frame_done) n_done++;
        end
    end

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [199:0] exp_win(input int r, input int c);
        logic [199:0] w = '0;
        for (int rr = 0; rr < 5; rr++) begin
            for (int cc = 0; cc < 5; cc++) begin
                w[40*rr + 8*cc +: 8] = 8'(W*(r - 4 + rr) + (c - 4 + cc));
            end
        end
        return w;
    endfunction

    // Returns with the pixel presented and accepted at the next posedge.
    task automatic send_pixel(input int idx, input bit gaps);
        int guard = 0;
        bit taken = 1'b0;
        while (!taken) begin
            @(posedge clk);
            #1;
            window_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            pix_in       = 8'(idx);
            pix_valid    = !(gaps && ($urandom_range(0, 2) == 0));
            #1;
            taken = pix_valid && pix_ready;
            guard++;
            if (!taken && guard > 200) begin
                n_fail++;
                $display("FAIL send_pixel %0d: not accepted after %0d cycles, acceptance required",
                         idx, guard);
                $fatal(1, "input stalled");
            end
        end
    endtask

    task automatic send_range(input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++) send_pixel(i, gaps);
    endtask

    task automatic finish_pixel();
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic drain(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            pix_valid    = 1'b0;
            window_ready = 1'b1;
        end
    endtask

    task automatic check_frame(input int base, input string name);
        logic [199:0] w;
        for (int i = 0; i < NWIN; i++) begin
            w = (base + i < got_q.size()) ? got_q[base + i] : 'x;
            check($sformatf("%s win%0d br", name, i), 200'(w[199:192]), 200'(vecs[i].br));
            check($sformatf("%s win%0d tl", name, i), 200'(w[7:0]), 200'(vecs[i].tl));
            check($sformatf("%s win%0d full", name, i), w, exp_win(vecs[i].row, vecs[i].col));
        end
    endtask

    initial begin
        vecs = '{
            '{4, 4, 8'd0,  8'd36}, '{4, 5, 8'd1,  8'd37}, '{4, 6, 8'd2,  8'd38},
            '{4, 7, 8'd3,  8'd39}, '{5, 4, 8'd8,  8'd44}, '{5, 5, 8'd9,  8'd45},
            '{5, 6, 8'd10, 8'd46}, '{5, 7, 8'd11, 8'd47}, '{6, 4, 8'd16, 8'd52},
            '{6, 5, 8'd17, 8'd53}, '{6, 6, 8'd18, 8'd54}, '{6, 7, 8'd19, 8'd55},
            '{7, 4, 8'd24, 8'd60}, '{7, 5, 8'd25, 8'd61}, '{7, 6, 8'd26, 8'd62},
            '{7, 7, 8'd27, 8'd63}
        };
        rst_n        = 1'b0;
        pix_in       = '0;
        pix_valid    = 1'b0;
        window_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset window_valid", 200'(window_valid), 200'(0));
        check("reset frame_done", 200'(frame_done), 200'(0));
        check("reset window_out", window_out, '0);
        check("reset pix_ready", 200'(pix_ready), 200'(1));
        rst_n = 1'b1;
        #1;
        check("post-reset pix_ready", 200'(pix_ready), 200'(1));

        // Frame A: free-running, plus frame_done timing after pixel (7,7)
        got_q.delete();
        n_done = 0;
        send_range(0, 63, 1'b0);
        finish_pixel();
        check("A frame_done pulse", 200'(frame_done), 200'(1));
        @(posedge clk);
        #1;
        check("A frame_done falls", 200'(frame_done), 200'(0));
        drain(4);
        check("A window count", 200'(got_q.size()), 200'(NWIN));
        check("A frame_done count", 200'(n_done), 200'(1));
        check_frame(0, "A");

        // Frame B: stall five cycles on the first window
        got_q.delete();
        n_done = 0;
        send_range(0, 36, 1'b0);
        @(posedge clk);
        #1;
        window_ready = 1'b0;
        pix_valid    = 1'b1;
        pix_in       = 8'd37;
        check("B first window valid", 200'(window_valid), 200'(1));
        check("B first window br", 200'(window_out[199:192]), 200'(36));
        check("B first window tl", 200'(window_out[7:0]), 200'(0));
        saved = window_out;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            #1;
            check($sformatf("B stall%0d pix_ready", k), 200'(pix_ready), 200'(0));
            check($sformatf("B stall%0d valid", k), 200'(window_valid), 200'(1));
            check($sformatf("B stall%0d window", k), window_out, saved);
        end
        send_range(37, 63, 1'b0);
        finish_pixel();
        drain(4);
        check("B window count", 200'(got_q.size()), 200'(NWIN));
        check("B frame_done count", 200'(n_done), 200'(1));
        check_frame(0, "B");

        // Frame C: random input gaps and random downstream ready
        got_q.delete();
        n_done   = 0;
        rdy_mode = 2;
        send_range(0, 63, 1'b1);
        finish_pixel();
        rdy_mode = 1;
        drain(6);
        check("C window count", 200'(got_q.size()), 200'(NWIN));
        check("C frame_done count", 200'(n_done), 200'(1));
        check_frame(0, "C");

        // Two back-to-back frames
        got_q.delete();
        n_done = 0;
        send_range(0, 63, 1'b0);
        send_range(0, 63, 1'b0);
        finish_pixel();
        drain(4);
        check("BB window count", 200'(got_q.size()), 200'(2 * NWIN));
        check("BB frame_done count", 200'(n_done), 200'(2));
        check_frame(0, "BB1");
        check_frame(NWIN, "BB2");

        // Reset mid-frame after pixel (5,3)
        send_range(0, 43, 1'b0);
        finish_pixel();
        rst_n = 1'b0;
        #1;
        check("midrst window_valid", 200'(window_valid), 200'(0));
        check("midrst window_out", window_out, '0);
        check("midrst pix_ready", 200'(pix_ready), 200'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        send_range(0, 35, 1'b0);
        finish_pixel();
        check("restart no early window", 200'(got_q.size()), 200'(0));
        check("restart valid before (4,4)", 200'(window_valid), 200'(0));
        send_pixel(36, 1'b0);
        finish_pixel();
        check("restart window valid", 200'(window_valid), 200'(1));
        check("restart window br", 200'(window_out[199:192]), 200'(36));
        check("restart window full", window_out, exp_win(4, 4));
        drain(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/window_generator_5x5.md
WINDOW_GENERATOR_5X5 -- requirements
Module: window_generator_5x5

Interface
REQ-001 Parameter IMG_WIDTH, default 64, pixels per line (legal range 5..1024).
REQ-002 Parameter IMG_HEIGHT, default 64, lines per frame (legal range 5..1024).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 pix_in  input  8  raster-order pixel, left-to-right, top-to-bottom.
REQ-006 pix_valid  input  1  pix_in is valid this cycle.
REQ-007 pix_ready  output  1  block accepts pix_in this cycle.
REQ-008 window_out  output  200  5x5 window, 25 pixels x 8 bits, filter input format.
REQ-009 window_valid  output  1  window_out is valid.
REQ-010 window_ready  input  1  downstream filter accepts window_out this cycle.
REQ-011 frame_done  output  1  one-cycle pulse on acceptance of the last pixel of a frame.

Function
REQ-012 Input transfer occurs on a cycle with pix_valid && pix_ready; output transfer on window_valid && window_ready.
REQ-013 pix_ready = !window_valid || window_ready (combinational; single output register, no extra buffering).
REQ-014 Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) advance only on input transfer; col wraps to 0 and row increments at col = IMG_WIDTH-1.
REQ-015 At col = IMG_WIDTH-1, row = IMG_HEIGHT-1: both counters wrap to 0, and frame_done pulses high for exactly the following cycle.
REQ-016 Four line buffers of IMG_WIDTH x 8 bits hold the previous four lines; on each input transfer the column at col shifts up by one line and pix_in is written as the newest line.
REQ-017 A 5x5 register window shifts left by one column on each input transfer, loading the new column (4 buffered lines plus pix_in).
REQ-018 Window layout: row r (0 = oldest/top .. 4 = newest/bottom) occupies bits [40r+39:40r]; column c (0 = leftmost .. 4 = rightmost) occupies bits [40r+8c+7:40r+8c].
REQ-019 A window is produced only when the accepted pixel has row >= 4 and col >= 4. No padding; windows never span a line or frame boundary.
REQ-020 Latency: window_valid rises on the cycle after the input transfer that completes the window; window_out then holds the pixel at (row, col) in bits [199:192].
REQ-021 While window_valid && !window_ready: window_out and window_valid hold stable and pix_ready = 0, so no input is accepted.
REQ-022 window_valid falls after an output transfer unless a new window completes on the same cycle; in that case window_out reloads and window_valid stays high.
REQ-023 Windows per frame = (IMG_WIDTH-4) x (IMG_HEIGHT-4); stale line-buffer data from a previous frame never reaches an emitted window.
REQ-024 pix_valid low inserts bubbles only; counters and window contents are unchanged.

Reset
REQ-025 While rst_n = 0: col = 0, row = 0, window_valid = 0, frame_done = 0, window_out = 0, shift window = 0. pix_ready = 1 during and after reset.
REQ-026 Line-buffer memories are not reset; REQ-019 guarantees their contents are never exposed.
REQ-027 Reset mid-frame discards the partial frame; the first pixel after deassertion is treated as (0,0).

Verification (IMG_WIDTH = 8, IMG_HEIGHT = 8, pixel value = 8*row + col)
REQ-028 Stream one frame with window_ready = 1 -> exactly 16 windows. The first window has bits[7:0] = 0 and bits[199:192] = 36, one cycle after pixel (4,4) is accepted. The last window has bits[199:192] = 63.
REQ-029 Hold window_ready = 0 for 5 cycles at the first window -> window_out stays stable, pix_ready = 0 and the counters freeze; on release, transfers resume with no lost or duplicated window.
REQ-030 Random pix_valid gaps plus random window_ready -> the window sequence is identical to REQ-028.
REQ-031 Two back-to-back frames -> frame_done pulses once per frame, one cycle after pixel (7,7). The second frame also yields 16 windows, and its first window has bits[7:0] = 0.
REQ-032 Assert rst_n low after pixel (5,3) -> window_valid = 0 immediately. After restart, no window appears before a new pixel (4,4), and that window has bits[199:192] = 36.
